// File: rtl/tt_adder_pkg.sv
// Shared types and width helpers for the tt_adder_accum block.
package tt_adder_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_RSVD = 2'b11
  } tt_mode_e;

  // Width of the full operand sum: WIDTH + clog2(LANES).
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned lanes);
    return width + $unsigned($clog2(lanes));
  endfunction

endpackage

// File: rtl/tt_adder_pair_stage.sv
// Stage 1 of the adder tree: LANES/2 pair adders with enabled output registers.
module tt_adder_pair_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_en,
  input  logic [LANES*WIDTH-1:0]              i_operands,
  output logic [(LANES/2)*(WIDTH+1)-1:0]      o_pair_sums
);

  localparam int unsigned PAIRS = LANES / 2;
  localparam int unsigned PW    = WIDTH + 1;

  logic [PAIRS*PW-1:0] w_pair_sums;
  logic [PAIRS*PW-1:0] r_pair_sums;

  always_comb begin
    w_pair_sums = '0;
    for (int p = 0; p < int'(PAIRS); p++) begin
      w_pair_sums[p*PW +: PW] = PW'(i_operands[(2*p)*WIDTH +: WIDTH])
                              + PW'(i_operands[(2*p+1)*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair_sums <= '0;
    end else if (i_en) begin
      r_pair_sums <= w_pair_sums;
    end
  end

  assign o_pair_sums = r_pair_sums;

endmodule

// File: rtl/tt_adder_accum.sv
// Two-stage LANES-operand adder tree with SUM/ACC/LOAD accumulator and sticky overflow.
// Build option: define SATURATE_EN to clamp ACC results at all-ones instead of wrapping.
module tt_adder_accum
  import tt_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] operands,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       result,
  output logic                   ovf
);

  localparam int unsigned SUM_W = sum_width(WIDTH, LANES);
  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned PAIRS = LANES / 2;

  logic                w_adv;
  logic                w_accept;
  logic [PAIRS*PW-1:0] w_pair_sums;
  logic [SUM_W-1:0]    w_total_n;
  logic [ACC_W-1:0]    w_total;
  logic [ACC_W:0]      w_acc_sum;
  logic                w_carry;
  logic [ACC_W-1:0]    w_acc_next;

  logic                r_s1_valid;
  tt_mode_e            r_s1_mode;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_result;
  logic                r_out_valid;
  logic                r_ovf;

  // The whole pipe advances only when the output slot is free or draining.
  assign w_adv    = !r_out_valid || out_ready;
  assign w_accept = in_valid && w_adv;

  tt_adder_pair_stage #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_pair_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_accept),
    .i_operands  (operands),
    .o_pair_sums (w_pair_sums)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_SUM;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode <= tt_mode_e'(mode);
      end
    end
  end

  always_comb begin
    w_total_n = '0;
    for (int i = 0; i < int'(PAIRS); i++) begin
      w_total_n = w_total_n + SUM_W'(w_pair_sums[i*PW +: PW]);
    end
  end

  assign w_total   = ACC_W'(w_total_n);
  assign w_acc_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_total);
  assign w_carry   = w_acc_sum[ACC_W];

  always_comb begin
    w_acc_next = w_acc_sum[ACC_W-1:0];
`ifdef SATURATE_EN
    if (w_carry) begin
      w_acc_next = '1;
    end
`endif
  end

  // Stage 2: mode-dependent result and accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        case (r_s1_mode)
          MODE_ACC: begin
            r_acc    <= w_acc_next;
            r_result <= w_acc_next;
            if (w_carry) begin
              r_ovf <= 1'b1;
            end
          end
          MODE_LOAD: begin
            r_acc    <= w_total;
            r_result <= w_total;
            r_ovf    <= 1'b0;
          end
          default: begin
            r_result <= w_total;
          end
        endcase
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule
